tiled_weight_controller: RTL and testbench
==========================================

// Module: tiled_weight_controller
// PURPOSE
//  Row-serial weight store and updater for the layer-multiplexed network; supersedes the full-matrix controller.
//  Holds 2**LAYER_ADDR_WIDTH weight matrices of NEURON_NUM x NEURON_NUM cells in an internal register array.
//  Serves forward-pass reads and backward-pass jobs (w -= a*delta), streaming one matrix row per handshake.
//  A backward job streams out the pre-update rows for delta propagation.
// PARAMETERS
//  NEURON_NUM          5                   neurons per layer; matrix rows and columns
//  LAYER_ADDR_WIDTH    2                   layer address width; LAYER_NUM = 1<<LAYER_ADDR_WIDTH
//  ACTIVATION_WIDTH    9                   signed activation cell width
//  DELTA_CELL_WIDTH    10                  signed delta cell width
//  WEIGHT_CELL_WIDTH   16                  signed weight cell width
//  FRACTION_WIDTH      0                   fixed-point fraction bits of the a*delta product
//  LEARNING_RATE_SHIFT 0                   extra arithmetic right shift applied to the product
//  WEIGHT_INIT_FILE    "weight_init.list"  $readmemh image, row-major, layer-major
// PORTS
//  clk           in   1                      clock
//  rst           in   1                      asynchronous, active-low reset
//  upd_layer     in   LAYER_ADDR_WIDTH       layer to update (backward job)
//  upd_a         in   NEURON_NUM*ACTIVATION_WIDTH  activations, column c = cell c
//  upd_delta     in   NEURON_NUM*DELTA_CELL_WIDTH  deltas, row r = cell r
//  upd_valid     in   1                      job valid
//  upd_ready     out  1                      job accepted
//  layer_fw      in   LAYER_ADDR_WIDTH       layer to read (forward)
//  layer_fw_valid in  1                      forward request valid
//  layer_fw_ready out 1                      forward request accepted
//  w_bw          out  NEURON_NUM*WEIGHT_CELL_WIDTH  pre-update row
//  w_bw_row      out  clog2(NEURON_NUM)      row index of w_bw
//  w_bw_last     out  1                      last row of the job
//  w_bw_valid    out  1                      w_bw valid
//  w_bw_ready    in   1                      w_bw consumed
//  w_fw          out  NEURON_NUM*WEIGHT_CELL_WIDTH  current row
//  w_fw_row      out  clog2(NEURON_NUM)      row index of w_fw
//  w_fw_last     out  1                      last row
//  w_fw_valid    out  1                      w_fw valid
//  w_fw_ready    in   1                      w_fw consumed
//  error         out  1                      sticky update overflow
// BEHAVIOUR
//  - Reset (async, rst=0): FSM to IDLE; row counter 0; upd_ready, layer_fw_ready, all *_valid, *_last and error = 0.
//    The arbiter last-grant register resets to FW, so BW wins the first tie. The weight array is not reset.
//  - FSM states:
//    - IDLE: upd_ready/layer_fw_ready are registered grants, at most one high per cycle.
//      Both requests valid: grant the one not granted last (round-robin). One valid: grant it.
//      On the accept edge, latch layer, a and delta (BW) or layer (FW); go to BW or FW with row=0.
//    - BW: w_bw_valid=1; w_bw=mem[layer][row], read combinationally; w_bw_last=(row==NEURON_NUM-1).
//      On w_bw_valid&w_bw_ready the updated row is written to mem in that same edge and row increments.
//      After the last row is written, go to IDLE.
//    - FW: w_fw_valid=1, same row stream, no write; row advances on handshake; after last row, go to IDLE.
//  - Latency: accept edge -> row 0 valid next cycle; one row per cycle while ready is high.
//    A job costs NEURON_NUM+1 cycles including the IDLE turnaround.
//  - Backpressure: while valid and not ready, data, row and last stay stable and memory is untouched.
//  - Jobs never overlap: a FW read after a BW job on the same layer returns the updated values.
//    No read-during-write hazard exists.
//  - Arithmetic, cell (r,c): p = a[c]*delta[r], signed, ACTIVATION_WIDTH+DELTA_CELL_WIDTH bits.
//    q = p >>> (FRACTION_WIDTH+LEARNING_RATE_SHIFT).
//    n = w[r][c] - q, computed at max(A+D,WEIGHT)+1 bits, then fitted to WEIGHT_CELL_WIDTH.
//    n outside the signed WEIGHT range sets error (sticky until reset).
//  - Reset mid-job: rows already handshaken stay updated, the remaining rows keep their old values.
//    Outputs return to reset values.
// CONFIGURATION
//  TILED_WEIGHT_CTRL_SATURATE_EN defined: an overflowing n clamps to +2**(W-1)-1 or -2**(W-1).
//  Undefined: n wraps (low WEIGHT_CELL_WIDTH bits kept). error behaves identically in both builds.
// TESTING
//  1 Init layer1 all 100; upd layer1, a all 2, delta all 3 -> w_bw rows 0..4 all 100, last on row 4.
//    Then FW read of layer1 -> all cells 94, error=0.
//  2 w=32760, a=-256, delta=511 -> with _EN: cell 32767, error=1; without: cell wraps to 32760+130816 mod 2**16, error=1.
//  3 upd_valid and layer_fw_valid both high in IDLE after reset -> BW granted first, FW granted right after BW last row.
//  4 w_bw_ready low for 3 cycles at row 2 -> w_bw and w_bw_row=2 held stable, mem row 2 unchanged until handshake.
//  5 rst=0 after row 1 handshake -> valids=0, error=0; FW read shows rows 0-1 updated, rows 2-4 original.
//  6 Back-to-back FW reads of layers 0 and 3 with ready high -> 5 rows each, an IDLE cycle between, correct layer data.

Source files
------------

// File: rtl/tiled_weight_controller.sv
// Row-serial weight store: forward reads and backward w -= a*delta jobs, one matrix row per handshake.
// Build option: define TILED_WEIGHT_CTRL_SATURATE_EN to clamp overflowing cells instead of wrapping.

module tiled_weight_lane #(
  parameter int ACTIVATION_WIDTH  = 9,
  parameter int DELTA_CELL_WIDTH  = 10,
  parameter int WEIGHT_CELL_WIDTH = 16,
  parameter int SHIFT             = 0
) (
  input  logic [WEIGHT_CELL_WIDTH-1:0] w,
  input  logic [ACTIVATION_WIDTH-1:0]  a,
  input  logic [DELTA_CELL_WIDTH-1:0]  delta,
  output logic [WEIGHT_CELL_WIDTH-1:0] n,
  output logic                         ovf
);
  localparam int P  = ACTIVATION_WIDTH + DELTA_CELL_WIDTH;
  localparam int W  = WEIGHT_CELL_WIDTH;
  localparam int NW = ((P > W) ? P : W) + 1;

  logic signed [P-1:0]  a_x, d_x, p, q;
  logic signed [NW-1:0] diff;

  assign a_x  = P'($signed(a));
  assign d_x  = P'($signed(delta));
  assign p    = a_x * d_x;
  assign q    = p >>> SHIFT;
  assign diff = NW'($signed(w)) - NW'(q);
  // In range only if every bit above the weight sign bit matches it.
  assign ovf  = (diff[NW-1:W-1] != {(NW-W+1){diff[W-1]}});

`ifdef TILED_WEIGHT_CTRL_SATURATE_EN
  assign n = !ovf ? diff[W-1:0] :
             diff[NW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
  assign n = diff[W-1:0];
`endif
endmodule

module tiled_weight_controller #(
  parameter int    NEURON_NUM          = 5,
  parameter int    LAYER_ADDR_WIDTH    = 2,
  parameter int    ACTIVATION_WIDTH    = 9,
  parameter int    DELTA_CELL_WIDTH    = 10,
  parameter int    WEIGHT_CELL_WIDTH   = 16,
  parameter int    FRACTION_WIDTH      = 0,
  parameter int    LEARNING_RATE_SHIFT = 0,
  parameter string WEIGHT_INIT_FILE    = "weight_init.list",
  localparam int   ROW_W = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [LAYER_ADDR_WIDTH-1:0]             upd_layer,
  input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]  upd_a,
  input  logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0]  upd_delta,
  input  logic                                    upd_valid,
  output logic                                    upd_ready,
  input  logic [LAYER_ADDR_WIDTH-1:0]             layer_fw,
  input  logic                                    layer_fw_valid,
  output logic                                    layer_fw_ready,
  output logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] w_bw,
  output logic [ROW_W-1:0]                        w_bw_row,
  output logic                                    w_bw_last,
  output logic                                    w_bw_valid,
  input  logic                                    w_bw_ready,
  output logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] w_fw,
  output logic [ROW_W-1:0]                        w_fw_row,
  output logic                                    w_fw_last,
  output logic                                    w_fw_valid,
  input  logic                                    w_fw_ready,
  output logic                                    error
);
  localparam int LAYER_NUM = 1 << LAYER_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BW, FW} state_t;

  state_t                                               state;
  logic [ROW_W-1:0]                                     row;
  logic [LAYER_ADDR_WIDTH-1:0]                          layer_q;
  logic [NEURON_NUM-1:0][ACTIVATION_WIDTH-1:0]          a_q;
  logic [NEURON_NUM-1:0][DELTA_CELL_WIDTH-1:0]          delta_q;
  logic                                                 last_bw;
  logic [NEURON_NUM-1:0][WEIGHT_CELL_WIDTH-1:0]         rd_row, wr_row;
  logic [NEURON_NUM-1:0]                                ovf;
  logic [DELTA_CELL_WIDTH-1:0]                          delta_row;
  logic                                                 bw_hs, fw_hs;

  // Weight image is preloaded by the integration flow (WEIGHT_INIT_FILE) and never reset.
  logic [NEURON_NUM-1:0][WEIGHT_CELL_WIDTH-1:0] mem [LAYER_NUM][NEURON_NUM];

  assign rd_row    = mem[layer_q][row];
  assign delta_row = delta_q[row];
  assign bw_hs     = w_bw_valid & w_bw_ready;
  assign fw_hs     = w_fw_valid & w_fw_ready;

  assign w_bw      = rd_row;
  assign w_fw      = rd_row;
  assign w_bw_row  = row;
  assign w_fw_row  = row;

  for (genvar c = 0; c < NEURON_NUM; c++) begin : g_lane
    tiled_weight_lane #(
      .ACTIVATION_WIDTH (ACTIVATION_WIDTH),
      .DELTA_CELL_WIDTH (DELTA_CELL_WIDTH),
      .WEIGHT_CELL_WIDTH(WEIGHT_CELL_WIDTH),
      .SHIFT            (FRACTION_WIDTH + LEARNING_RATE_SHIFT)
    ) u_lane (
      .w    (rd_row[c]),
      .a    (a_q[c]),
      .delta(delta_row),
      .n    (wr_row[c]),
      .ovf  (ovf[c])
    );
  end

  always_ff @(posedge clk) begin
    if (bw_hs) mem[layer_q][row] <= wr_row;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      row            <= '0;
      layer_q        <= '0;
      a_q            <= '0;
      delta_q        <= '0;
      last_bw        <= 1'b0;
      upd_ready      <= 1'b0;
      layer_fw_ready <= 1'b0;
      w_bw_valid     <= 1'b0;
      w_bw_last      <= 1'b0;
      w_fw_valid     <= 1'b0;
      w_fw_last      <= 1'b0;
      error          <= 1'b0;
    end else begin
      // Grants are single-cycle pulses seen in the first cycle of the job.
      upd_ready      <= 1'b0;
      layer_fw_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (upd_valid && (!layer_fw_valid || !last_bw)) begin
            upd_ready  <= 1'b1;
            last_bw    <= 1'b1;
            layer_q    <= upd_layer;
            a_q        <= upd_a;
            delta_q    <= upd_delta;
            row        <= '0;
            w_bw_valid <= 1'b1;
            w_bw_last  <= (NEURON_NUM == 1);
            state      <= BW;
          end else if (layer_fw_valid) begin
            layer_fw_ready <= 1'b1;
            last_bw        <= 1'b0;
            layer_q        <= layer_fw;
            row            <= '0;
            w_fw_valid     <= 1'b1;
            w_fw_last      <= (NEURON_NUM == 1);
            state          <= FW;
          end
        end
        BW: begin
          if (bw_hs) begin
            if (|ovf) error <= 1'b1;
            if (w_bw_last) begin
              w_bw_valid <= 1'b0;
              w_bw_last  <= 1'b0;
              row        <= '0;
              state      <= IDLE;
            end else begin
              row       <= row + 1'b1;
              w_bw_last <= (row == ROW_W'(NEURON_NUM - 2));
            end
          end
        end
        FW: begin
          if (fw_hs) begin
            if (w_fw_last) begin
              w_fw_valid <= 1'b0;
              w_fw_last  <= 1'b0;
              row        <= '0;
              state      <= IDLE;
            end else begin
              row       <= row + 1'b1;
              w_fw_last <= (row == ROW_W'(NEURON_NUM - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tiled_weight_controller.sv
// Randomized bench for tiled_weight_controller against an arithmetic matrix model.
module tb_tiled_weight_controller;
  localparam int N  = 5;
  localparam int LA = 2;
  localparam int AW = 9;
  localparam int DW = 10;
  localparam int WW = 16;
  localparam int RW = 3;
  localparam int LN = 1 << LA;
  localparam int SH = 0;
  localparam longint WMAX = (longint'(1) <<< (WW - 1)) - 1;
  localparam longint WMIN = -(longint'(1) <<< (WW - 1));

  logic            clk = 0;
  logic            rst = 0;
  logic [LA-1:0]   upd_layer = '0;
  logic [N*AW-1:0] upd_a = '0;
  logic [N*DW-1:0] upd_delta = '0;
  logic            upd_valid = 0;
  logic            upd_ready;
  logic [LA-1:0]   layer_fw = '0;
  logic            layer_fw_valid = 0;
  logic            layer_fw_ready;
  logic [N*WW-1:0] w_bw, w_fw;
  logic [RW-1:0]   w_bw_row, w_fw_row;
  logic            w_bw_last, w_bw_valid, w_fw_last, w_fw_valid;
  logic            w_bw_ready = 0, w_fw_ready = 0;
  logic            error;

  tiled_weight_controller dut (
    .clk(clk), .rst(rst),
    .upd_layer(upd_layer), .upd_a(upd_a), .upd_delta(upd_delta),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .layer_fw(layer_fw), .layer_fw_valid(layer_fw_valid), .layer_fw_ready(layer_fw_ready),
    .w_bw(w_bw), .w_bw_row(w_bw_row), .w_bw_last(w_bw_last),
    .w_bw_valid(w_bw_valid), .w_bw_ready(w_bw_ready),
    .w_fw(w_fw), .w_fw_row(w_fw_row), .w_fw_last(w_fw_last),
    .w_fw_valid(w_fw_valid), .w_fw_ready(w_fw_ready),
    .error(error)
  );

  always #5 clk = ~clk;

  int  vecs = 0, fails = 0;
  int  model [LN][N][N];
  int  ja [N], jd [N];
  bit  m_err = 0;
  int  cur_layer = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int upd_cell(input int w, input int a, input int d);
    longint p, n;
    p = (longint'(a) * longint'(d)) >>> SH;
    n = longint'(w) - p;
    if (n > WMAX || n < WMIN) begin
      m_err = 1;
`ifdef TILED_WEIGHT_CTRL_SATURATE_EN
      n = (n > 0) ? WMAX : WMIN;
`else
      n = ((n % 65536) + 65536) % 65536;
      if (n > WMAX) n -= 65536;
`endif
    end
    return int'(n);
  endfunction

  function automatic logic [N*WW-1:0] pack_row(input int l, input int r);
    logic [N*WW-1:0] x;
    for (int c = 0; c < N; c++) x[c*WW +: WW] = model[l][r][c][WW-1:0];
    return x;
  endfunction

  task automatic load_layer(input int l, input bit rnd, input int val);
    logic [N*WW-1:0] x;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++)
        model[l][r][c] = rnd ? int'($urandom_range(0, 65535)) - 32768 : val;
      x = pack_row(l, r);
      dut.mem[l][r] = x;
    end
  endtask

  task automatic set_job(input bit rnd, input int av, input int dv);
    for (int i = 0; i < N; i++) begin
      ja[i] = rnd ? int'($urandom_range(0, 511)) - 256  : av;
      jd[i] = rnd ? int'($urandom_range(0, 1023)) - 512 : dv;
      upd_a[i*AW +: AW]     = ja[i][AW-1:0];
      upd_delta[i*DW +: DW] = jd[i][DW-1:0];
    end
  endtask

  // Raise the request at a negedge, wait for the grant pulse, then drop valid.
  task automatic request(input bit bw, input int l);
    int cyc = 0;
    cur_layer = l;
    if (bw) begin upd_layer = LA'(l); upd_valid = 1; end
    else begin layer_fw = LA'(l); layer_fw_valid = 1; end
    @(negedge clk);
    while (!(bw ? upd_ready : layer_fw_ready) && cyc < 20) begin @(negedge clk); cyc++; end
    check("grant",     bw ? upd_ready : layer_fw_ready, 1);
    check("grant_one", bw ? layer_fw_ready : upd_ready, 0);
    check("grant_lat", cyc, 0);
    if (bw) upd_valid = 0; else layer_fw_valid = 0;
  endtask

  // mode 0: ready always; 1: random ready; 2: 3-cycle stall at row 2.
  task automatic stream(input bit bw, input int mode, input int abort_row);
    int  r = 0, stall = 0, guard = 0;
    bit  done = 0, rdy;
    logic [N*WW-1:0] exp;
    while (!done) begin
      exp = pack_row(cur_layer, r);
      check("valid", bw ? w_bw_valid : w_fw_valid, 1);
      check("row",   bw ? w_bw_row : w_fw_row, r);
      check("data",  bw ? w_bw : w_fw, exp);
      check("last",  bw ? w_bw_last : w_fw_last, r == N - 1);
      if (r == abort_row) begin w_bw_ready = 0; w_fw_ready = 0; return; end
      case (mode)
        0:       rdy = 1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: begin rdy = !(r == 2 && stall < 3); if (!rdy) stall++; end
      endcase
      if (mode == 2 && !rdy) check("mem_hold", dut.mem[cur_layer][2], exp);
      if (bw) w_bw_ready = rdy; else w_fw_ready = rdy;
      if (rdy) begin
        if (bw) for (int c = 0; c < N; c++)
          model[cur_layer][r][c] = upd_cell(model[cur_layer][r][c], ja[c], jd[r]);
        if (r == N - 1) done = 1; else r++;
      end
      @(negedge clk);
      if (++guard > 200) begin check("stream_tmo", done, 1); done = 1; end
    end
    w_bw_ready = 0; w_fw_ready = 0;
    check("valid_drop", bw ? w_bw_valid : w_fw_valid, 0);
    check("error", error, m_err);
  endtask

  task automatic check_reset_state();
    check("rst_upd_ready", upd_ready, 0);
    check("rst_fw_ready",  layer_fw_ready, 0);
    check("rst_bw_valid",  w_bw_valid, 0);
    check("rst_fw_valid",  w_fw_valid, 0);
    check("rst_bw_last",   w_bw_last, 0);
    check("rst_fw_last",   w_fw_last, 0);
    check("rst_error",     error, 0);
  endtask

  initial begin
    for (int l = 0; l < LN; l++) load_layer(l, 1, 0);
    load_layer(1, 0, 100);
    #12;
    check_reset_state();
    @(negedge clk); rst = 1;
    @(negedge clk);

    // Spec example: 100 - 2*3 = 94 everywhere, no overflow.
    set_job(0, 2, 3);
    request(1, 1); stream(1, 0, -1);
    request(0, 1); stream(0, 0, -1);
    check("t1_cell", w_fw[WW-1:0], 16'd94);

    // Overflow: 32760 - (-256*511).
    load_layer(2, 0, 32760);
    set_job(0, -256, 511);
    request(1, 2); stream(1, 0, -1);
    request(0, 2); stream(0, 1, -1);
    check("t2_error", error, 1);

    // Reset after row 1 handshake.
    set_job(1, 0, 0);
    request(1, 0); stream(1, 0, 2);
    rst = 0; #1;
    check_reset_state();
    m_err = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
    request(0, 0); stream(0, 0, -1);

    // Tie after reset: BW first, FW right after its last row.
    set_job(1, 0, 0);
    layer_fw = 2'd1; layer_fw_valid = 1;
    request(1, 1); stream(1, 0, -1);
    request(0, 1); stream(0, 0, -1);

    // Tie after a BW grant: FW wins.
    request(1, 3); stream(1, 1, -1);
    upd_layer = 2'd3; upd_valid = 1;
    request(0, 3); stream(0, 0, -1);
    request(1, 3); stream(1, 0, -1);

    // Backpressure stall at row 2.
    set_job(1, 0, 0);
    request(1, 2); stream(1, 2, -1);
    request(0, 2); stream(0, 2, -1);

    // Back-to-back forward reads.
    request(0, 0); stream(0, 0, -1);
    request(0, 3); stream(0, 0, -1);

    for (int it = 0; it < 12; it++) begin
      set_job(1, 0, 0);
      if ($urandom_range(0, 1) != 0) begin
        request(1, int'($urandom_range(0, LN - 1))); stream(1, 1, -1);
      end else begin
        request(0, int'($urandom_range(0, LN - 1))); stream(0, 1, -1);
      end
    end
    for (int l = 0; l < LN; l++) begin request(0, l); stream(0, 0, -1); end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
